// File: rtl/dna_pkg.sv
// Shared types and sizing for the DNA_PORT request arbiter.
package dna_pkg;

   localparam int DNA_W = 57;

   function automatic int dna_cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int DNA_CNT_W = dna_cnt_w(DNA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } dna_state_e;

endpackage

// File: rtl/dna_rr_arb.sv
// Round-robin winner selection; ptr_q is the highest-priority index for the next pick.
module dna_rr_arb #(
   parameter int NUM_REQ = 4
) (
   input  logic               sys_clk,
   input  logic               sys_nrst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               adv,
   input  logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] win
);
   import dna_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             found;

   // First pass covers ptr..NUM_REQ-1, second pass wraps around to the rest.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req[j] && (j >= int'(ptr_q))) begin
            win[j] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req[j]) begin
            win[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) ptr_d = (j == NUM_REQ - 1) ? '0 : IDX_W'(j + 1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) ptr_q <= '0;
      else           ptr_q <= ptr_d;
   end

endmodule

// File: rtl/dna_req_arb.sv
// Arbitrates requesters onto a single DNA_PORT and returns the serial-read identifier.
// Optional build macro DNA_CACHE_EN: after the first read, answer from the capture register.
//
// state | meaning
// IDLE  | waiting for any req; winner registered into gnt on the exit edge
// LOAD  | one cycle, dna_read=1 latches the DNA into the port shifter
// SHIFT | DNA_W cycles capturing dna_dout MSB-first; dna_shift on all but the last
// DONE  | one cycle, rsp_vld=gnt with rsp_data, pointer advances, gnt clears
module dna_req_arb #(
   parameter int NUM_REQ = 4,
   parameter int DNA_W   = dna_pkg::DNA_W
) (
   input  logic               sys_clk,
   input  logic               sys_nrst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] rsp_vld,
   output logic [DNA_W-1:0]   rsp_data,
   output logic               busy,
   output logic               dna_read,
   output logic               dna_shift,
   input  logic               dna_dout
);
   import dna_pkg::*;

   localparam int             CNT_W    = dna_cnt_w(DNA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_W - 1);

   dna_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DNA_W-1:0]   cap_q, cap_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] win;
   logic               use_cache;

   dna_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .sys_clk  (sys_clk),
      .sys_nrst (sys_nrst),
      .req      (req),
      .adv      (state_q == DONE),
      .gnt      (gnt_q),
      .win      (win)
   );

`ifdef DNA_CACHE_EN
   logic cache_q;

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst)              cache_q <= 1'b0;
      else if (state_q == DONE)   cache_q <= 1'b1;
   end

   assign use_cache = cache_q;
`else
   assign use_cache = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = win;
               state_d = use_cache ? DONE : LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            cap_d = {cap_q[DNA_W-2:0], dna_dout};
            if (cnt_q == CNT_LAST) state_d = DONE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         DONE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         gnt_q   <= gnt_d;
      end
   end

   // Outputs decode from registered state so the async reset clears them at once.
   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign dna_read  = (state_q == LOAD);
   assign dna_shift = (state_q == SHIFT) && (cnt_q != CNT_LAST);
   assign rsp_vld   = (state_q == DONE) ? gnt_q : '0;
   assign rsp_data  = (state_q == DONE) ? cap_q : '0;

endmodule
